ready_tracker: RTL

- Parametrised occupancy and per-slot ready tracker for a circular line buffer of 2^BufferWidth slots.
- Successor to the fixed 4-slot ready decoder: owns the write/read pointers and wrap (Round) bits internally instead of taking them as inputs.
- Adds write/read handshakes, full/empty/almost-full status, flush, and optional sticky error flags.
- Sits between the buffer-fill logic and the convolution datapath that consumes buffered rows.

---
 rtl/ready_tracker.sv | 106 ++++++++++
 1 files changed

// File: rtl/ready_tracker.sv
// Occupancy and per-slot ready tracker for a circular line buffer of 2**BufferWidth slots.
// Optional sticky Overflow/Underflow flags are built when READY_TRACKER_ERR_EN is defined.
module ready_tracker #(
   parameter int BufferWidth     = 2,
   parameter int AlmostFullLevel = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        W_En,
   input  logic                        R_En,
   input  logic                        Flush,
   output logic                        W_Ready,
   output logic                        R_Valid,
   output logic [BufferWidth-1:0]      W_Addr,
   output logic [BufferWidth-1:0]      R_Addr,
   output logic [(2**BufferWidth)-1:0] Ready,
   output logic [BufferWidth:0]        Count,
   output logic                        Full,
   output logic                        Empty,
   output logic                        Almost_Full,
   output logic                        Overflow,
   output logic                        Underflow
);

   localparam int BufferSize = 2**BufferWidth;
   localparam logic [BufferWidth-1:0] LastSlot = BufferWidth'(BufferSize - 1);

   logic [BufferWidth-1:0] w_ptr;
   logic [BufferWidth-1:0] r_ptr;
   logic                   w_round;
   logic                   r_round;
   logic [BufferWidth:0]   count_q;
   logic                   ptr_eq;
   logic                   w_acc;
   logic                   r_acc;

   // Handshake: a write is taken on a cycle where W_En && W_Ready, a read where
   // R_En && R_Valid; both ready/valid depend on registered state only, and a
   // Flush or rst cycle takes neither.
   assign ptr_eq  = (w_ptr == r_ptr);
   assign Empty   = ptr_eq && (w_round == r_round);
   assign Full    = ptr_eq && (w_round != r_round);
   assign W_Ready = !Full;
   assign R_Valid = !Empty;
   assign W_Addr  = w_ptr;
   assign R_Addr  = r_ptr;
   assign Count   = count_q;
   assign Almost_Full = (count_q >= (BufferWidth+1)'(AlmostFullLevel));

   assign w_acc = W_En && W_Ready && !Flush;
   assign r_acc = R_En && R_Valid && !Flush;

   always_ff @(posedge clk) begin
      if (rst || Flush) begin
         w_ptr   <= '0;
         r_ptr   <= '0;
         w_round <= 1'b0;
         r_round <= 1'b0;
         count_q <= '0;
      end else begin
         if (w_acc) begin
            w_ptr <= w_ptr + BufferWidth'(1);
            if (w_ptr == LastSlot) w_round <= ~w_round;
         end
         if (r_acc) begin
            r_ptr <= r_ptr + BufferWidth'(1);
            if (r_ptr == LastSlot) r_round <= ~r_round;
         end
         if (w_acc && !r_acc)      count_q <= count_q + (BufferWidth+1)'(1);
         else if (r_acc && !w_acc) count_q <= count_q - (BufferWidth+1)'(1);
      end
   end

   // Slot i is live when it lies in the circular window [r_ptr, w_ptr).
   always_comb begin
      Ready = '0;
      for (int i = 0; i < BufferSize; i++) begin
         if (w_round == r_round)
            Ready[i] = (BufferWidth'(i) >= r_ptr) && (BufferWidth'(i) < w_ptr);
         else
            Ready[i] = (BufferWidth'(i) >= r_ptr) || (BufferWidth'(i) < w_ptr);
      end
   end

`ifdef READY_TRACKER_ERR_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (W_En && Full && !Flush)  overflow_q  <= 1'b1;
         if (R_En && Empty && !Flush) underflow_q <= 1'b1;
      end
   end

   assign Overflow  = overflow_q;
   assign Underflow = underflow_q;
`else
   assign Overflow  = 1'b0;
   assign Underflow = 1'b0;
`endif

endmodule
